// File: rtl/eq_step_scheduler.sv
// rtl/eq_step_scheduler.sv - clock-enable step scheduler for the ILA-vs-HLS equivalence harness
// Runs both designs, freezes ILA on completion, drains HLS, then strobes a compare or times out.
module eq_step_scheduler #(
  parameter int HLS_DRAIN  = 5,
  parameter int MAX_CYCLES = 64,
  parameter int CNT_W      = 16,
  parameter int DRAIN_W    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               ila_complete,
  input  logic               hls_complete,
  output logic               ila_en,
  output logic               hls_en,
  output logic               check_valid,
  output logic [1:0]         phase,
  output logic               busy,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [DRAIN_W-1:0] drain_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE,
    S_TIMEOUT
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(MAX_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LIM = DRAIN_W'(HLS_DRAIN);
  localparam logic [DRAIN_W-1:0] DRAIN_SAT = DRAIN_W'(HLS_DRAIN + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               hls_window;

  // HLS keeps stepping until the drain counter passes the drain allowance.
  assign hls_window = (drain_cnt_q <= DRAIN_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cycle_cnt_d = cycle_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (clear) begin
      state_d     = S_IDLE;
      cycle_cnt_d = '0;
      drain_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cycle_cnt_d = '0;
          drain_cnt_d = '0;
          if (start) state_d = S_RUN;
        end
        S_RUN: begin
          cycle_cnt_d = (cycle_cnt_q >= CNT_MAX) ? CNT_MAX : cycle_cnt_q + 1'b1;
          if (hls_complete)
            drain_cnt_d = (drain_cnt_q >= DRAIN_SAT) ? DRAIN_SAT : drain_cnt_q + 1'b1;
          else
            drain_cnt_d = '0;
          // Finish takes priority over the budget check on the same edge.
          if (ila_complete && !hls_window) state_d = S_CHECK;
          else if (cycle_cnt_q == CNT_LAST) state_d = S_TIMEOUT;
        end
        S_CHECK:   state_d = S_DONE;
        S_DONE:    state_d = S_DONE;
        S_TIMEOUT: state_d = S_TIMEOUT;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    phase = 2'd0;
    case (state_q)
      S_CHECK:   phase = 2'd1;
      S_DONE:    phase = 2'd2;
      S_TIMEOUT: phase = 2'd3;
      default:   phase = 2'd0;
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign timeout     = (state_q == S_TIMEOUT);
  assign check_valid = (state_q == S_CHECK);
  assign ila_en      = busy & ~ila_complete;
  assign hls_en      = busy & hls_window;
  assign cycle_cnt   = cycle_cnt_q;
  assign drain_cnt   = drain_cnt_q;

endmodule

// File: tb/tb_eq_step_scheduler.sv
// tb/tb_eq_step_scheduler.sv - scoreboard bench for eq_step_scheduler
// Stimulus pushes per-cycle expected outputs; a negedge monitor pops and compares.
module tb_eq_step_scheduler;

  logic        clk = 1'b0;
  logic        rst, start, clear, ila_complete, hls_complete;
  logic        ila_en, hls_en, check_valid, busy, timeout;
  logic [1:0]  phase;
  logic [15:0] cycle_cnt;
  logic [7:0]  drain_cnt;

  int tests  = 0;
  int failed = 0;

  logic [30:0] exp_q[$];
  string       name_q[$];
  logic [30:0] mon_exp, mon_act;
  string       mon_name;

  eq_step_scheduler #(.HLS_DRAIN(5), .MAX_CYCLES(64), .CNT_W(16), .DRAIN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .ila_complete(ila_complete), .hls_complete(hls_complete),
    .ila_en(ila_en), .hls_en(hls_en), .check_valid(check_valid), .phase(phase),
    .busy(busy), .timeout(timeout), .cycle_cnt(cycle_cnt), .drain_cnt(drain_cnt)
  );

  always #5 clk = ~clk;

  // Packed as {ila_en, hls_en, check_valid, phase[1:0], busy, timeout, cycle_cnt, drain_cnt}.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {ila_en, hls_en, check_valid, phase, busy, timeout, cycle_cnt, drain_cnt};
      tests++;
      if (mon_act !== mon_exp) begin
        failed++;
        $display("FAIL %s: got ie=%b he=%b cv=%b ph=%0d bz=%b to=%b cc=%0d dc=%0d, expected ie=%b he=%b cv=%b ph=%0d bz=%b to=%b cc=%0d dc=%0d",
                 mon_name, mon_act[30], mon_act[29], mon_act[28], mon_act[27:26], mon_act[25],
                 mon_act[24], mon_act[23:8], mon_act[7:0], mon_exp[30], mon_exp[29], mon_exp[28],
                 mon_exp[27:26], mon_exp[25], mon_exp[24], mon_exp[23:8], mon_exp[7:0]);
      end
    end
  end

  task automatic push(input string nm, input bit ie, input bit he, input bit cv,
                      input bit [1:0] ph, input bit bz, input bit to, input int cc, input int dc);
    exp_q.push_back({ie, he, cv, ph, bz, to, 16'(cc), 8'(dc)});
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string nm);
    push(nm, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic launch(input string nm);
    start = 1'b1;
    push(nm, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    tick();
    start = 1'b0;
  endtask

  task automatic clear_cycle(input string nm, input bit [1:0] ph, input bit to, input int cc, input int dc);
    clear = 1'b1;
    push(nm, 0, 0, 0, ph, 0, to, cc, dc);
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; clear = 1'b0; ila_complete = 1'b0; hls_complete = 1'b0;
    push("reset", 0, 0, 0, 2'd0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    rst = 1'b0;

    // 1: HLS done at 2, ILA done at 3 -> hls_en low at 8, CHECK at 9.
    launch("s1_idle");
    for (int n = 0; n <= 8; n++) begin
      ila_complete = (n >= 3);
      hls_complete = (n >= 2);
      push($sformatf("s1_run%0d", n), n < 3, n < 8, 0, 2'd0, 1, 0, n,
           (n <= 2) ? 0 : ((n - 2 > 6) ? 6 : n - 2));
      tick();
    end
    push("s1_check", 0, 0, 1, 2'd1, 0, 0, 9, 6);
    tick();
    start = 1'b1;
    push("s1_done0", 0, 0, 0, 2'd2, 0, 0, 9, 6);
    tick();
    push("s1_done1", 0, 0, 0, 2'd2, 0, 0, 9, 6);
    tick();
    start = 1'b0;
    clear_cycle("s1_clear", 2'd2, 0, 9, 6);
    ila_complete = 1'b0; hls_complete = 1'b0;
    idle_check("s1_idle_after");

    // 2: ILA late at 20, HLS drained at 8 -> CHECK at 21.
    launch("s2_idle");
    for (int n = 0; n <= 20; n++) begin
      ila_complete = (n >= 20);
      hls_complete = (n >= 2);
      push($sformatf("s2_run%0d", n), n < 20, n < 8, 0, 2'd0, 1, 0, n,
           (n <= 2) ? 0 : ((n - 2 > 6) ? 6 : n - 2));
      tick();
    end
    push("s2_check", 0, 0, 1, 2'd1, 0, 0, 21, 6);
    tick();
    push("s2_done", 0, 0, 0, 2'd2, 0, 0, 21, 6);
    tick();
    clear_cycle("s2_clear", 2'd2, 0, 21, 6);
    ila_complete = 1'b0; hls_complete = 1'b0;
    idle_check("s2_idle_after");

    // 3: hls_complete 1,1,0,1 restarts the drain window; never finishes.
    launch("s3_idle");
    for (int n = 0; n <= 6; n++) begin
      int dc_tab[7] = '{0, 1, 2, 0, 1, 0, 0};
      hls_complete = (n == 0) || (n == 1) || (n == 3);
      push($sformatf("s3_run%0d", n), 1, 1, 0, 2'd0, 1, 0, n, dc_tab[n]);
      if (n == 6) clear = 1'b1;
      tick();
    end
    clear = 1'b0; hls_complete = 1'b0;
    idle_check("s3_idle_after");

    // 4: nothing completes -> TIMEOUT after cycle_cnt=63, counter saturates at 64.
    launch("s4_idle");
    for (int n = 0; n <= 63; n++) begin
      push($sformatf("s4_run%0d", n), 1, 1, 0, 2'd0, 1, 0, n, 0);
      tick();
    end
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push($sformatf("s4_timeout%0d", k), 0, 0, 0, 2'd3, 0, 1, 64, 0);
      tick();
    end
    start = 1'b0;
    clear_cycle("s4_clear", 2'd3, 1, 64, 0);
    idle_check("s4_idle_after");

    // 5: finish and timeout coincide at cycle 63 -> CHECK wins.
    launch("s5_idle");
    for (int n = 0; n <= 63; n++) begin
      ila_complete = 1'b1;
      hls_complete = (n >= 57);
      push($sformatf("s5_run%0d", n), 0, n < 63, 0, 2'd0, 1, 0, n,
           (n <= 57) ? 0 : ((n - 57 > 6) ? 6 : n - 57));
      tick();
    end
    push("s5_check", 0, 0, 1, 2'd1, 0, 0, 64, 6);
    tick();
    push("s5_done", 0, 0, 0, 2'd2, 0, 0, 64, 6);
    tick();
    clear_cycle("s5_clear", 2'd2, 0, 64, 6);
    ila_complete = 1'b0; hls_complete = 1'b0;
    idle_check("s5_idle_after");

    // 6: async reset between edges mid-RUN drops everything immediately.
    launch("s6_idle");
    for (int n = 0; n <= 4; n++) begin
      hls_complete = (n >= 3);
      push($sformatf("s6_run%0d", n), 1, 1, 0, 2'd0, 1, 0, n, (n <= 3) ? 0 : 1);
      tick();
    end
    rst = 1'b1;
    push("s6_rst_mid", 0, 0, 0, 2'd0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    push("s6_after_rst", 0, 0, 0, 2'd0, 0, 0, 0, 0);
    tick();
    hls_complete = 1'b0;
    launch("s6_idle2");
    push("s6_rerun0", 1, 1, 0, 2'd0, 1, 0, 0, 0);
    tick();
    push("s6_rerun1", 1, 1, 0, 2'd0, 1, 0, 1, 0);
    tick();

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
